elbeth_bus_demux_1_to_2: RTL and testbench
==========================================

Name: elbeth_bus_demux_1_to_2

Overview:
- Routes one 32-bit master data-bus request to one of two slave ports (slave 1: memory, slave 2: I/O), selected by address decode.
- Latches each request, holds the selected slave's request until that slave responds, then returns read data and status to the master.
- Steering counterpart of the 32-bit 2-to-1 select muxes in the datapath: one request fans out to two targets, and the response comes back from the chosen one.
- Sits between the core's load/store unit and the memory / peripheral buses.

Parameters:
- S2_BASE, 32'h8000_0000, address match value for slave 2.
- S2_MASK, 32'hF000_0000, address bits compared against S2_BASE.
- TIMEOUT_CYCLES, 255, wait-cycle limit before a timeout error; used only with the optional feature; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  1  single-cycle request pulse from the master.
- m_addr  in  32  request address; valid with m_req.
- m_wdata  in  32  write data; valid with m_req.
- m_byte_sel  in  4  byte enables; valid with m_req.
- m_we  in  1  1 = write, 0 = read.
- m_rdata  out  32  registered read data.
- m_ready  out  1  one-cycle pulse: transaction completed OK.
- m_error  out  1  one-cycle pulse: transaction failed.
- m_busy  out  1  high while a transaction is outstanding.
- s1_req, s2_req  out  1  per-slave request level.
- s1_addr / s2_addr  out  32  latched address (shared register).
- s1_wdata / s2_wdata  out  32  latched write data (shared register).
- s1_byte_sel / s2_byte_sel  out  4  latched byte enables (shared register).
- s1_we / s2_we  out  1  latched write flag (shared register).
- s1_rdata, s2_rdata  in  32  slave read data.
- s1_ready, s2_ready  in  1  slave completion.
- s1_error, s2_error  in  1  slave error.

Behaviour:
- Reset values: all outputs 0; FSM state IDLE.
- Reset mid-transaction: the request is abandoned; sN_req is low after the edge; no m_ready or m_error is produced.
- FSM states: IDLE, WAIT_1, WAIT_2, RESP.
- IDLE or RESP with m_req=1:
  - Latch addr, wdata, byte_sel and we.
  - Decode: (m_addr & S2_MASK) == (S2_BASE & S2_MASK) goes to WAIT_2, otherwise WAIT_1.
- IDLE with m_req=0: stay in IDLE.
- RESP with m_req=0: go to IDLE.
- WAIT_n:
  - sN_req=1 for the selected slave only; the other slave's req stays 0.
  - Stay in WAIT_n until sN_ready or sN_error, then go to RESP.
- Response capture:
  - Capture sN_rdata into m_rdata only on ready without error.
  - In RESP, assert m_ready or m_error for exactly one cycle.
- Simultaneous sN_ready and sN_error: error wins; m_error=1, m_ready=0, m_rdata unchanged.
- Latency: m_req in cycle 0 gives sN_req in cycles 1..k, where k is the slave-ready cycle; m_ready in cycle k+1. A zero-wait slave gives m_ready in cycle 2.
- Back-to-back: m_req accepted in the RESP cycle starts the next transaction with no idle cycle.
- m_req while in WAIT_1/WAIT_2: ignored; no latch update, no effect.
- ready/error from the non-selected slave, or any slave while in IDLE: ignored.
- m_busy = 1 in WAIT_1 and WAIT_2, 0 otherwise.
- m_rdata holds its last captured value between transactions.

Optional Feature:
- Macro: ELBETH_BUS_DEMUX_TIMEOUT_EN.
- When defined:
  - 16-bit wait counter, cleared on entry to WAIT_n and incremented each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES with no slave response: drop sN_req, go to RESP, pulse m_error.
  - A slave response in the same cycle as the timeout takes priority over the timeout.
- When undefined: no counter; WAIT_n waits indefinitely.

Test Plan:
- Read, slave 1: m_req, m_addr=0x0000_0100; s1_ready in cycle 1 with s1_rdata=0xDEAD_BEEF -> s1_req high in cycle 1 only, m_ready and m_rdata=0xDEAD_BEEF in cycle 2, s2_req stays 0.
- Write, slave 2: m_addr=0x8000_0010, m_wdata=0x1234_5678, m_byte_sel=4'b0011, m_we=1; s2_ready after 3 wait cycles -> s2_addr/s2_wdata/s2_byte_sel/s2_we match, s2_req high for 4 cycles, one m_ready pulse, m_rdata unchanged.
- Error priority: s1_ready=1 and s1_error=1 together -> m_error=1, m_ready=0, m_rdata keeps its previous value.
- Back-to-back and ignore rule:
  - m_req accepted in the RESP cycle -> next sN_req starts immediately, no idle cycle.
  - m_req with a different address during WAIT -> ignored, latched address unchanged.
- Reset mid-op: rst in cycle 2 of a WAIT_1 -> s1_req=0 and m_busy=0 next cycle; no m_ready/m_error; a later s1_ready is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=4): slave never responds -> s1_req high for 4 cycles, then one m_error pulse and return to IDLE.

Source files
------------

// File: rtl/elbeth_bus_demux_1_to_2.sv
// -----------------------------------------------------------------------------
// elbeth_bus_demux_1_to_2
//
// Purpose:
//    Steers one 32-bit master bus request to one of two slave ports. Slave 1
//    is memory and slave 2 is I/O, and an address decode picks the slave.
//    The request is latched and held on the chosen slave until that slave
//    responds. The response then returns to the master as a one-cycle
//    m_ready or m_error pulse. Read data comes back through the registered
//    m_rdata.
//
// Ports:
//    clk, rst            - clock (rising edge), synchronous active-high reset
//    m_req               - single-cycle request pulse from the master
//    m_addr / m_wdata    - request address and write data (valid with m_req)
//    m_byte_sel / m_we   - byte enables and write flag (valid with m_req)
//    m_rdata             - registered read data, holds between transactions
//    m_ready / m_error   - one-cycle completion / failure pulse
//    m_busy              - high while a slave request is outstanding
//    s1_*/s2_*           - per-slave request level, shared latched request
//                          fields, and slave rdata/ready/error returns
//
// Optional feature (macro ELBETH_BUS_DEMUX_TIMEOUT_EN):
//    Adds a 16-bit wait counter. If the slave does not respond within
//    TIMEOUT_CYCLES wait cycles, the request is dropped and m_error pulses.
//    Without the macro, a wait lasts until the slave responds.
// -----------------------------------------------------------------------------
module elbeth_bus_demux_1_to_2 #(
   parameter logic [31:0] S2_BASE        = 32'h8000_0000,
   parameter logic [31:0] S2_MASK        = 32'hF000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_req,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_byte_sel,
   input  logic        m_we,
   output logic [31:0] m_rdata,
   output logic        m_ready,
   output logic        m_error,
   output logic        m_busy,
   output logic        s1_req,
   output logic [31:0] s1_addr,
   output logic [31:0] s1_wdata,
   output logic [3:0]  s1_byte_sel,
   output logic        s1_we,
   input  logic [31:0] s1_rdata,
   input  logic        s1_ready,
   input  logic        s1_error,
   output logic        s2_req,
   output logic [31:0] s2_addr,
   output logic [31:0] s2_wdata,
   output logic [3:0]  s2_byte_sel,
   output logic        s2_we,
   input  logic [31:0] s2_rdata,
   input  logic        s2_ready,
   input  logic        s2_error
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT_1 = 2'd1;
   localparam logic [1:0] ST_WAIT_2 = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Elaboration-time check of the timeout parameter range.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   logic [1:0]  state;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_byte_sel;
   logic        lat_we;

   logic        waiting;
   logic        accept;
   logic        sel_s2;
   logic        rsp_ready;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic        timeout_hit;

   assign waiting = (state == ST_WAIT_1) || (state == ST_WAIT_2);
   // A new request is taken only when no transaction is outstanding. A
   // request that arrives in RESP is taken too, so there is no idle cycle.
   assign accept  = m_req && ((state == ST_IDLE) || (state == ST_RESP));
   assign sel_s2  = (m_addr & S2_MASK) == (S2_BASE & S2_MASK);

   // Only the selected slave's response is visible. Any response outside
   // a WAIT state is masked off.
   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      rsp_ready = 1'b0;
      rsp_error = 1'b0;
      rsp_rdata = s1_rdata;
      if (state == ST_WAIT_1) begin
         rsp_ready = s1_ready;
         rsp_error = s1_error;
      end else if (state == ST_WAIT_2) begin
         rsp_ready = s2_ready;
         rsp_error = s2_error;
         rsp_rdata = s2_rdata;
      end
   end

`ifdef ELBETH_BUS_DEMUX_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;

   // The counter is 0 in the first wait cycle. It therefore equals
   // TIMEOUT_LAST in the TIMEOUT_CYCLES-th wait cycle, which is the last
   // cycle the request is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (waiting) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   assign timeout_hit = waiting && (wait_cnt == TIMEOUT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: all sequential state uses non-blocking assignments, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_byte_sel <= '0;
         lat_we       <= 1'b0;
         m_rdata      <= '0;
         m_ready      <= 1'b0;
         m_error      <= 1'b0;
      end else begin
         m_ready <= 1'b0;
         m_error <= 1'b0;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  lat_addr     <= m_addr;
                  lat_wdata    <= m_wdata;
                  lat_byte_sel <= m_byte_sel;
                  lat_we       <= m_we;
                  state        <= sel_s2 ? ST_WAIT_2 : ST_WAIT_1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               // An error wins over ready. A real slave response wins over
               // a timeout in the same cycle.
               if (rsp_error) begin
                  m_error <= 1'b1;
                  state   <= ST_RESP;
               end else if (rsp_ready) begin
                  m_ready <= 1'b1;
                  // A write carries no read data, so m_rdata keeps the
                  // last value that a read returned.
                  if (!lat_we) begin
                     m_rdata <= rsp_rdata;
                  end
                  state <= ST_RESP;
               end else if (timeout_hit) begin
                  m_error <= 1'b1;
                  state   <= ST_RESP;
               end
            end
         endcase
      end
   end

   assign m_busy      = waiting;
   assign s1_req      = (state == ST_WAIT_1);
   assign s2_req      = (state == ST_WAIT_2);
   assign s1_addr     = lat_addr;
   assign s2_addr     = lat_addr;
   assign s1_wdata    = lat_wdata;
   assign s2_wdata    = lat_wdata;
   assign s1_byte_sel = lat_byte_sel;
   assign s2_byte_sel = lat_byte_sel;
   assign s1_we       = lat_we;
   assign s2_we       = lat_we;

endmodule

// File: tb/tb_elbeth_bus_demux_1_to_2.sv
// -----------------------------------------------------------------------------
// tb_elbeth_bus_demux_1_to_2
//
// Purpose:
//    Directed bench for elbeth_bus_demux_1_to_2. Inputs change 1 ns after a
//    rising edge, and outputs are sampled at that same point. A check made
//    after N edges therefore shows the state that edge N produced. The
//    timeout sequence is built only when ELBETH_BUS_DEMUX_TIMEOUT_EN is
//    defined.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_elbeth_bus_demux_1_to_2;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_byte_sel;
   logic        m_we;
   logic [31:0] m_rdata;
   logic        m_ready;
   logic        m_error;
   logic        m_busy;
   logic        s1_req;
   logic [31:0] s1_addr;
   logic [31:0] s1_wdata;
   logic [3:0]  s1_byte_sel;
   logic        s1_we;
   logic [31:0] s1_rdata;
   logic        s1_ready;
   logic        s1_error;
   logic        s2_req;
   logic [31:0] s2_addr;
   logic [31:0] s2_wdata;
   logic [3:0]  s2_byte_sel;
   logic        s2_we;
   logic [31:0] s2_rdata;
   logic        s2_ready;
   logic        s2_error;

   int n_cmp = 0;
   int n_err = 0;

   elbeth_bus_demux_1_to_2 #(
      .S2_BASE        (32'h8000_0000),
      .S2_MASK        (32'hF000_0000),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req       (m_req),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_byte_sel  (m_byte_sel),
      .m_we        (m_we),
      .m_rdata     (m_rdata),
      .m_ready     (m_ready),
      .m_error     (m_error),
      .m_busy      (m_busy),
      .s1_req      (s1_req),
      .s1_addr     (s1_addr),
      .s1_wdata    (s1_wdata),
      .s1_byte_sel (s1_byte_sel),
      .s1_we       (s1_we),
      .s1_rdata    (s1_rdata),
      .s1_ready    (s1_ready),
      .s1_error    (s1_error),
      .s2_req      (s2_req),
      .s2_addr     (s2_addr),
      .s2_wdata    (s2_wdata),
      .s2_byte_sel (s2_byte_sel),
      .s2_we       (s2_we),
      .s2_rdata    (s2_rdata),
      .s2_ready    (s2_ready),
      .s2_error    (s2_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_resp(input string tag, input logic rdy, input logic err);
      check({tag, ".m_ready"}, {31'd0, m_ready}, {31'd0, rdy});
      check({tag, ".m_error"}, {31'd0, m_error}, {31'd0, err});
   endtask

   initial begin
      rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_byte_sel = '0; m_we = 1'b0;
      s1_rdata = '0; s1_ready = 1'b0; s1_error = 1'b0;
      s2_rdata = '0; s2_ready = 1'b0; s2_error = 1'b0;
      tick();
      tick();

      // Reset state: every output is 0.
      check("rst.m_rdata", m_rdata, 32'h0);
      check_resp("rst", 1'b0, 1'b0);
      check("rst.m_busy", {31'd0, m_busy}, 32'd0);
      check("rst.s1_req", {31'd0, s1_req}, 32'd0);
      check("rst.s2_req", {31'd0, s2_req}, 32'd0);
      check("rst.s1_addr", s1_addr, 32'h0);
      rst = 1'b0;
      tick();

      // Read from slave 1 with a zero-wait response.
      m_req = 1'b1; m_addr = 32'h0000_0100; m_we = 1'b0;
      tick();                                    // cycle 1
      check("rd1.s1_req", {31'd0, s1_req}, 32'd1);
      check("rd1.s2_req", {31'd0, s2_req}, 32'd0);
      check("rd1.m_busy", {31'd0, m_busy}, 32'd1);
      check("rd1.s1_addr", s1_addr, 32'h0000_0100);
      m_req = 1'b0;
      s1_ready = 1'b1; s1_rdata = 32'hDEAD_BEEF;
      tick();                                    // cycle 2
      check_resp("rd1.c2", 1'b1, 1'b0);
      check("rd1.m_rdata", m_rdata, 32'hDEAD_BEEF);
      check("rd1.c2.s1_req", {31'd0, s1_req}, 32'd0);
      check("rd1.c2.m_busy", {31'd0, m_busy}, 32'd0);
      s1_ready = 1'b0; s1_rdata = 32'h0;
      tick();
      check_resp("rd1.c3", 1'b0, 1'b0);
      check("rd1.hold", m_rdata, 32'hDEAD_BEEF);

      // Write to slave 2. s2_ready arrives in the fourth request cycle.
      m_req = 1'b1; m_addr = 32'h8000_0010; m_wdata = 32'h1234_5678;
      m_byte_sel = 4'b0011; m_we = 1'b1;
      tick();                                    // cycle 1
      check("wr2.s2_req.c1", {31'd0, s2_req}, 32'd1);
      check("wr2.s1_req", {31'd0, s1_req}, 32'd0);
      check("wr2.s2_addr", s2_addr, 32'h8000_0010);
      check("wr2.s2_wdata", s2_wdata, 32'h1234_5678);
      check("wr2.s2_byte_sel", {28'd0, s2_byte_sel}, 32'h3);
      check("wr2.s2_we", {31'd0, s2_we}, 32'd1);
      m_req = 1'b0; m_we = 1'b0; m_byte_sel = 4'b0;
      s1_ready = 1'b1;                           // non-selected slave: ignored
      tick();                                    // cycle 2
      check("wr2.s2_req.c2", {31'd0, s2_req}, 32'd1);
      check_resp("wr2.c2", 1'b0, 1'b0);
      s1_ready = 1'b0;
      tick();                                    // cycle 3
      check("wr2.s2_req.c3", {31'd0, s2_req}, 32'd1);
      tick();                                    // cycle 4
      check("wr2.s2_req.c4", {31'd0, s2_req}, 32'd1);
      s2_ready = 1'b1; s2_rdata = 32'hBAD0_0001;
      tick();                                    // cycle 5: RESP
      check_resp("wr2.c5", 1'b1, 1'b0);
      check("wr2.s2_req.c5", {31'd0, s2_req}, 32'd0);
      check("wr2.m_rdata", m_rdata, 32'hDEAD_BEEF);
      s2_ready = 1'b0; s2_rdata = 32'h0;
      tick();
      check_resp("wr2.c6", 1'b0, 1'b0);

      // Error priority: ready and error arrive together.
      m_req = 1'b1; m_addr = 32'h0000_0200;
      tick();
      m_req = 1'b0;
      s1_ready = 1'b1; s1_error = 1'b1; s1_rdata = 32'h5555_AAAA;
      tick();                                    // RESP
      check_resp("errp", 1'b0, 1'b1);
      check("errp.m_rdata", m_rdata, 32'hDEAD_BEEF);
      s1_ready = 1'b0; s1_error = 1'b0; s1_rdata = 32'h0;

      // Back-to-back: a request taken in RESP goes straight to slave 2.
      m_req = 1'b1; m_addr = 32'h8000_0040; m_we = 1'b0;
      tick();
      check("b2b.s2_req", {31'd0, s2_req}, 32'd1);
      check("b2b.s2_addr", s2_addr, 32'h8000_0040);
      check_resp("b2b", 1'b0, 1'b0);

      // A request during WAIT is ignored and leaves the latches unchanged.
      m_req = 1'b1; m_addr = 32'h0000_0300; m_we = 1'b1;
      tick();
      check("ign.s2_addr", s2_addr, 32'h8000_0040);
      check("ign.s2_we", {31'd0, s2_we}, 32'd0);
      check("ign.s1_req", {31'd0, s1_req}, 32'd0);
      check("ign.s2_req", {31'd0, s2_req}, 32'd1);
      m_req = 1'b0; m_we = 1'b0;
      s2_ready = 1'b1; s2_rdata = 32'hCAFE_F00D;
      tick();                                    // RESP
      check_resp("ign.resp", 1'b1, 1'b0);
      check("ign.m_rdata", m_rdata, 32'hCAFE_F00D);
      s2_ready = 1'b0; s2_rdata = 32'h0;

      // Back-to-back into slave 1, then reset in the second WAIT_1 cycle.
      m_req = 1'b1; m_addr = 32'h0000_0400;
      tick();                                    // WAIT_1 cycle 1
      check("b2b1.s1_req", {31'd0, s1_req}, 32'd1);
      check("b2b1.s1_addr", s1_addr, 32'h0000_0400);
      m_req = 1'b0;
      tick();                                    // WAIT_1 cycle 2
      rst = 1'b1;
      tick();
      check("rmid.s1_req", {31'd0, s1_req}, 32'd0);
      check("rmid.m_busy", {31'd0, m_busy}, 32'd0);
      check_resp("rmid", 1'b0, 1'b0);
      check("rmid.m_rdata", m_rdata, 32'h0);
      rst = 1'b0;
      s1_ready = 1'b1; s1_rdata = 32'h1111_2222;  // late response: ignored
      tick();
      check_resp("rmid.late", 1'b0, 1'b0);
      check("rmid.late.m_rdata", m_rdata, 32'h0);
      check("rmid.late.m_busy", {31'd0, m_busy}, 32'd0);
      s1_ready = 1'b0; s1_rdata = 32'h0;
      tick();

`ifdef ELBETH_BUS_DEMUX_TIMEOUT_EN
      // Timeout with TIMEOUT_CYCLES=4: the request is held for 4 cycles.
      m_req = 1'b1; m_addr = 32'h0000_0500;
      tick();
      m_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to.s1_req", {31'd0, s1_req}, 32'd1);
         check_resp("to.wait", 1'b0, 1'b0);
         tick();
      end
      check_resp("to.resp", 1'b0, 1'b1);
      check("to.s1_req.drop", {31'd0, s1_req}, 32'd0);
      tick();
      check_resp("to.idle", 1'b0, 1'b0);
      check("to.m_busy", {31'd0, m_busy}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
